// File: rtl/banked_regfile.sv
// ---------------------------------------------------------------------------
// banked_regfile
//   ARMv4 register file with full processor-mode banking, prioritised write
//   ports, optional same-cycle write-through and a per-physical-register lock
//   scoreboard used by decode to stall on outstanding loads.
//
//   Physical layout (30 registers):
//     0-14  user r0-r14
//     15-21 FIQ  r8-r14
//     22-23 IRQ  r13-r14
//     24-25 SVC  r13-r14
//     26-27 ABT  r13-r14
//     28-29 UND  r13-r14
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              gates register writes and lock updates
//   i_mode          CPSR M[4:0]
//   i_user_bank     force the user bank for reads, writes and locks
//   i_rd_code       NUM_RD packed 4-bit read register codes
//   o_rd_data       NUM_RD packed read data words
//   o_rd_busy       per read port lock status
//   i_pc_next       value returned for r15 reads
//   i_wr_en/code/data/unlock  NUM_WR write ports, port 0 highest priority
//   i_lock_en/code  set the lock bit of a register
//   o_pc_en/o_pc_reg  r15 write redirect towards the fetch PC logic
// ---------------------------------------------------------------------------
module banked_regfile #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter bit BYPASS = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [4:0]               i_mode,
  input  logic                     i_user_bank,
  input  logic [4*NUM_RD-1:0]      i_rd_code,
  output logic [DATA_W*NUM_RD-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic [DATA_W-1:0]        i_pc_next,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [4*NUM_WR-1:0]      i_wr_code,
  input  logic [DATA_W*NUM_WR-1:0] i_wr_data,
  input  logic [NUM_WR-1:0]        i_wr_unlock,
  input  logic                     i_lock_en,
  input  logic [3:0]               i_lock_code,
  output logic                     o_pc_en,
  output logic [DATA_W-1:0]        o_pc_reg
);

  localparam int NUM_PHYS = 30;

  typedef enum logic [2:0] {
    BANK_USR,
    BANK_FIQ,
    BANK_IRQ,
    BANK_SVC,
    BANK_ABT,
    BANK_UND
  } bank_e;

  bank_e bank;

  logic [DATA_W-1:0]   regs_q [NUM_PHYS];
  logic [DATA_W-1:0]   regs_d [NUM_PHYS];
  logic [NUM_PHYS-1:0] lock_q;
  logic [NUM_PHYS-1:0] lock_d;

  logic [NUM_WR-1:0]   wrValid;
  logic [4:0]          wrIdx [NUM_WR];
  logic [4:0]          rdIdx [NUM_RD];
  logic [NUM_PHYS-1:0] lockSet;
  logic [NUM_PHYS-1:0] lockClr;

  // Map (bank, architectural code) to a physical index. Code 15 has no
  // storage; it returns 0 and every caller masks it out separately.
  function automatic logic [4:0] physIdx(input bank_e b, input logic [3:0] code);
    logic [4:0] c;
    logic       hiPair;
    c       = {1'b0, code};
    hiPair  = (code == 4'd13) || (code == 4'd14);
    physIdx = c;
    case (b)
      BANK_FIQ: if (code >= 4'd8)  physIdx = c + 5'd7;
      BANK_IRQ: if (hiPair)        physIdx = c + 5'd9;
      BANK_SVC: if (hiPair)        physIdx = c + 5'd11;
      BANK_ABT: if (hiPair)        physIdx = c + 5'd13;
      BANK_UND: if (hiPair)        physIdx = c + 5'd15;
      default:                     physIdx = c;
    endcase
    if (code == 4'd15) physIdx = 5'd0;
  endfunction

  // Reserved mode encodings fall back to the user bank, as does sys.
  always_comb begin
    bank = BANK_USR;
    if (!i_user_bank) begin
      case (i_mode)
        5'b10001: bank = BANK_FIQ;
        5'b10010: bank = BANK_IRQ;
        5'b10011: bank = BANK_SVC;
        5'b10111: bank = BANK_ABT;
        5'b11011: bank = BANK_UND;
        default:  bank = BANK_USR;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      wrIdx[k]   = physIdx(bank, i_wr_code[4*k +: 4]);
      wrValid[k] = en && i_wr_en[k] && (i_wr_code[4*k +: 4] != 4'd15);
    end
  end

  // Walking from the lowest-priority port up lets port 0 overwrite any
  // duplicate target last. Every unlocking write clears, winner or not.
  always_comb begin
    regs_d  = regs_q;
    lockClr = '0;
    lockSet = '0;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      if (wrValid[k]) begin
        regs_d[wrIdx[k]] = i_wr_data[DATA_W*k +: DATA_W];
        if (i_wr_unlock[k]) lockClr[wrIdx[k]] = 1'b1;
      end
    end
    if (en && i_lock_en && (i_lock_code != 4'd15))
      lockSet[physIdx(bank, i_lock_code)] = 1'b1;
    lock_d = (lock_q & ~lockClr) | lockSet;
  end

  // en is already folded into wrValid and lockSet, so the next state equals
  // the current state whenever en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHYS; i++) regs_q[i] <= '0;
      lock_q <= '0;
    end else begin
      regs_q <= regs_d;
      lock_q <= lock_d;
    end
  end

  // Reads. The lock bit is never bypassed, only data.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdIdx[p] = physIdx(bank, i_rd_code[4*p +: 4]);
      o_rd_data[DATA_W*p +: DATA_W] = regs_q[rdIdx[p]];
      o_rd_busy[p] = lock_q[rdIdx[p]];
      if (BYPASS) begin
        for (int k = NUM_WR - 1; k >= 0; k--) begin
          if (wrValid[k] && (wrIdx[k] == rdIdx[p]))
            o_rd_data[DATA_W*p +: DATA_W] = i_wr_data[DATA_W*k +: DATA_W];
        end
      end
      if (i_rd_code[4*p +: 4] == 4'd15) begin
        o_rd_data[DATA_W*p +: DATA_W] = i_pc_next;
        o_rd_busy[p] = 1'b0;
      end
    end
  end

  // r15 redirect is deliberately independent of en.
  always_comb begin
    o_pc_en  = 1'b0;
    o_pc_reg = '0;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      if (i_wr_en[k] && (i_wr_code[4*k +: 4] == 4'd15)) begin
        o_pc_en  = 1'b1;
        o_pc_reg = i_wr_data[DATA_W*k +: DATA_W];
      end
    end
  end

endmodule

// File: doc/banked_regfile.md
Name: banked_regfile

Overview:
- Parametrised ARMv4 register file with NUM_RD read ports and NUM_WR prioritised write ports.
- Full ARMv4 mode banking: FIQ banks r8-r14; IRQ, SVC, ABT and UND each bank r13-r14.
- Optional same-cycle write-through bypass.
- Per-physical-register lock scoreboard so the decode stage can stall on outstanding loads.
- Sits between decode (reads, locks) and the EX/WB stages (writes); r15 writes are redirected to the fetch PC logic.

Parameters:
- DATA_W, 32: register width in bits.
- NUM_RD, 4: number of read ports.
- NUM_WR, 2: number of write ports. Port 0 has the highest priority (EX), port NUM_WR-1 the lowest (WB).
- BYPASS, 0: when 1, read ports return same-cycle write data.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  global enable; gates register writes and scoreboard updates
- i_mode  in  5  CPSR M[4:0] of the current mode
- i_user_bank  in  1  force the USR bank for all reads, writes and locks (LDM/STM with ^)
- i_rd_code  in  4*NUM_RD  read register codes, port p in bits [4p+3:4p]
- o_rd_data  out  DATA_W*NUM_RD  read data
- o_rd_busy  out  NUM_RD  per read port: the register is locked
- i_pc_next  in  DATA_W  value returned for r15 reads
- i_wr_en  in  NUM_WR  write enables
- i_wr_code  in  4*NUM_WR  write register codes
- i_wr_data  in  DATA_W*NUM_WR  write data
- i_wr_unlock  in  NUM_WR  write also clears the lock bit
- i_lock_en  in  1  set the lock on i_lock_code
- i_lock_code  in  4  register to lock (current or user bank)
- o_pc_en  out  1  some write port targets r15
- o_pc_reg  out  DATA_W  r15 write data

Behaviour:
- Mode map:
  - 10000 usr and 11111 sys use the user bank.
  - 10001 fiq, 10010 irq, 10011 svc, 10111 abt, 11011 und use their own banks.
  - Any other encoding maps as usr.
  - i_user_bank=1 overrides the mode to usr.
- Physical storage: 30 registers.
  - 15 user: r0-r14.
  - 7 FIQ: r8-r14.
  - 2 each for IRQ, SVC, ABT, UND: r13-r14.
  - Combinational logic maps (mode, code) to a physical index.
- Reads are combinational.
  - Code 15 returns i_pc_next with busy=0.
  - Otherwise the port returns the mapped physical register and its lock bit.
- BYPASS=1: if any enabled write (en=1, code!=15) maps to the same physical register, the read returns the highest-priority write's data. Lock is not bypassed.
- Writes happen at posedge clk when en=1, i_wr_en[k]=1 and code!=15.
  - Several ports hitting the same physical register: lowest index wins.
  - Writes to different registers all commit in the same cycle.
- r15 writes:
  - o_pc_en = OR over k of (i_wr_en[k] and code==15). It is not gated by en.
  - o_pc_reg = data of the lowest-index port writing r15, else 0.
- Scoreboard: 30 lock bits, physical r15 never locked. Updated at posedge only when en=1.
  - A commit with i_wr_unlock[k]=1 clears the target's bit. A non-winning duplicate write that has i_wr_unlock set also clears it.
  - i_lock_en=1 with i_lock_code!=15 sets the mapped bit.
  - Set and clear on the same physical register in the same cycle: set wins.
  - i_lock_code==15 is ignored.
- A mode change does not move data. Locks stay attached to physical registers, so a banked r13 locked in SVC is not busy when read in IRQ.
- Reset (async, rst_n=0): all 30 registers = 0 and all lock bits = 0. Reset mid-operation discards pending locks. Outputs follow combinationally: o_rd_busy=0 and o_rd_data=0 except r15 reads.
- en=0: registers and lock bits hold; reads and o_pc_en/o_pc_reg remain live.

Test Plan:
- Reset, then in usr write r13=0x1111 via port 1; switch i_mode=10011 (svc), write r13=0x2222, read r13 -> 0x2222. Back to usr, read r13 -> 0x1111. Switch to sys, read r13 -> 0x1111.
- In fiq, write r8=0xAAAA; in usr, r8 -> 0 (reset value). In fiq with i_user_bank=1, r8 -> 0. In fiq with i_user_bank=0, r8 -> 0xAAAA.
- Ports 0 and 1 both write r5 in the same cycle (0x5, 0x6) -> r5=0x5 next cycle. Port 1 writes r15=0x100 while port 0 writes r15=0x200 -> o_pc_en=1, o_pc_reg=0x200, no register changes. Read r15 -> i_pc_next.
- Lock r3 -> next cycle o_rd_busy=1 for r3. Write r3 with unlock while also locking r3 in the same cycle -> still busy. Write with unlock alone -> busy=0 with data updated. Repeat with en=0 -> nothing changes.
- BYPASS=1: write r7=0x77 with a same-cycle read of r7 -> 0x77 in the same cycle. BYPASS=0: same stimulus -> old value, then 0x77 the next cycle.
- Assert rst_n mid-stream with locks and data set -> all reads 0 and all busy bits 0 immediately, without waiting for a clock edge.
